scd: RTL and testbench

- Shift-count/exponent datapath for the EBOX: 10-bit SCAD adder, SC (shift count) and FE (floating exponent) registers.
- Sits directly upstream of the EDP and feeds its ARMM inputs (SCD_ARMMupper, SCD_ARMMlower).
- Consumes EDP_AR and CRAM fields, and supplies SC/FE status to the microcode skip/dispatch logic.
- SC counts down microcode loops for shift, normalize, multiply and divide, and flags loop termination.

---
 rtl/scd_if.sv | 35 +++
 rtl/scd.sv | 92 +++++++++
 tb/tb_scd.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/scd_if.sv
// CRAM/AR inputs and SC/FE/SCAD results exchanged between the SCD datapath and its neighbours.
// MSB-first numbering matches the EBOX bit conventions (bit 0 is the sign).
interface scd_if;
  logic [2:0]   CRAM_SCAD;
  logic [1:0]   CRAM_SCADA;
  logic [1:0]   CRAM_SCADB;
  logic [1:0]   CRAM_SC;
  logic [1:0]   CRAM_FE;
  logic [0:8]   CRAM_MAGIC;
  logic         CRAM_ARMMsel;
  logic [0:35]  EDP_AR;
  logic [0:8]   SCD_ARMMupper;
  logic [13:17] SCD_ARMMlower;
  logic [0:9]   SCD_SCAD;
  logic [0:9]   SCD_SC;
  logic [0:9]   SCD_FE;
  logic         SCD_SCneg;
  logic         SCD_FEneg;
  logic         SCD_SCADeq0;
  logic         SCD_loopDone;

  modport master (
    output CRAM_SCAD, CRAM_SCADA, CRAM_SCADB, CRAM_SC, CRAM_FE,
           CRAM_MAGIC, CRAM_ARMMsel, EDP_AR,
    input  SCD_ARMMupper, SCD_ARMMlower, SCD_SCAD, SCD_SC, SCD_FE,
           SCD_SCneg, SCD_FEneg, SCD_SCADeq0, SCD_loopDone
  );

  modport slave (
    input  CRAM_SCAD, CRAM_SCADA, CRAM_SCADB, CRAM_SC, CRAM_FE,
           CRAM_MAGIC, CRAM_ARMMsel, EDP_AR,
    output SCD_ARMMupper, SCD_ARMMlower, SCD_SCAD, SCD_SC, SCD_FE,
           SCD_SCneg, SCD_FEneg, SCD_SCADeq0, SCD_loopDone
  );
endinterface

// File: rtl/scd.sv
// EBOX shift-count/exponent datapath: SCAD adder with A/B muxes, SC loop counter and FE exponent register.
// SC steps down microcode loops and pulses loopDone when a step carries it from 0 to negative.
module scd #(
  parameter int SCWIDTH = 10
) (
  input  logic  eboxClk,
  input  logic  eboxReset,
  scd_if.slave  bus
);

  logic [0:SCWIDTH-1] scad_a;
  logic [0:SCWIDTH-1] scad_b;
  logic [0:SCWIDTH-1] scad;
  logic [0:SCWIDTH-1] sc_q;
  logic [0:SCWIDTH-1] fe_q;
  logic               loop_done_q;
  logic               ar_sign;

  assign ar_sign = bus.EDP_AR[0];

  // AR exponent is stored one's-complemented when the word is negative, so undo it by sign.
  always_comb begin
    scad_a = '0;
    unique case (bus.CRAM_SCADA)
      2'd0: scad_a = fe_q;
      2'd1: scad_a = {ar_sign, ar_sign, bus.EDP_AR[1:8] ^ {8{ar_sign}}};
      2'd2: scad_a = {4'b0000, bus.EDP_AR[0:5]};
      2'd3: scad_a = {bus.CRAM_MAGIC[0], bus.CRAM_MAGIC};
      default: scad_a = '0;
    endcase
  end

  always_comb begin
    scad_b = '0;
    unique case (bus.CRAM_SCADB)
      2'd0: scad_b = sc_q;
      2'd1: scad_b = {4'b0000, bus.EDP_AR[6:11]};
      2'd2: scad_b = {ar_sign, bus.EDP_AR[0:8]};
      2'd3: scad_b = {bus.CRAM_MAGIC[0], bus.CRAM_MAGIC};
      default: scad_b = '0;
    endcase
  end

  always_comb begin
    scad = '0;
    unique case (bus.CRAM_SCAD)
      3'd0: scad = scad_a;
      3'd1: scad = scad_a - scad_b - 10'd1;
      3'd2: scad = scad_a + scad_b;
      3'd3: scad = scad_a - 10'd1;
      3'd4: scad = scad_a + 10'd1;
      3'd5: scad = scad_a - scad_b;
      3'd6: scad = scad_a | scad_b;
      3'd7: scad = scad_a & scad_b;
      default: scad = '0;
    endcase
  end

  // SC and FE each read the other's pre-edge value, so a same-cycle swap works.
  always_ff @(posedge eboxClk) begin
    if (eboxReset) begin
      sc_q        <= '0;
      fe_q        <= '0;
      loop_done_q <= 1'b0;
    end else begin
      unique case (bus.CRAM_SC)
        2'b01: sc_q <= scad;
        2'b10: sc_q <= sc_q - 10'd1;
        2'b11: sc_q <= '0;
        default: sc_q <= sc_q;
      endcase
      unique case (bus.CRAM_FE)
        2'b01: fe_q <= scad;
        2'b10: fe_q <= sc_q;
        2'b11: fe_q <= '0;
        default: fe_q <= fe_q;
      endcase
      loop_done_q <= (bus.CRAM_SC == 2'b10) && (sc_q == '0);
    end
  end

  assign bus.SCD_SCAD      = scad;
  assign bus.SCD_SCADeq0   = (scad == '0);
  assign bus.SCD_ARMMupper = bus.CRAM_ARMMsel ? {ar_sign, scad[2:9]} : scad[1:9];
  assign bus.SCD_ARMMlower = sc_q[5:9];
  assign bus.SCD_SC        = sc_q;
  assign bus.SCD_FE        = fe_q;
  assign bus.SCD_SCneg     = sc_q[0];
  assign bus.SCD_FEneg     = fe_q[0];
  assign bus.SCD_loopDone  = loop_done_q;

endmodule

// File: tb/tb_scd.sv
// Directed-vector bench for scd: reset, SC load/step/loopDone, exponent path, SCAD functions, swap and wrap.
module tb_scd;

  logic eboxClk;
  logic eboxReset;
  int   checkCount;
  int   errorCount;

  scd_if bus ();

  scd dut (
    .eboxClk   (eboxClk),
    .eboxReset (eboxReset),
    .bus       (bus)
  );

  initial eboxClk = 1'b0;
  always #5 eboxClk = ~eboxClk;

  task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] fn, input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] sc, input logic [1:0] fe, input logic [8:0] magic,
                               input logic armmSel);
    bus.CRAM_SCAD    = fn;
    bus.CRAM_SCADA   = a;
    bus.CRAM_SCADB   = b;
    bus.CRAM_SC      = sc;
    bus.CRAM_FE      = fe;
    bus.CRAM_MAGIC   = magic;
    bus.CRAM_ARMMsel = armmSel;
    #1;
  endtask

  task automatic tick();
    @(posedge eboxClk);
    #1;
  endtask

  initial begin
    logic [9:0] stepExp [4];
    logic       doneExp [4];
    checkCount = 0;
    errorCount = 0;
    stepExp = '{10'd2, 10'd1, 10'd0, 10'h3FF};
    doneExp = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Reset while loading: SCAD = 0x0AA + 0x0AB = 0x155
    eboxReset = 1'b1;
    bus.EDP_AR = '0;
    bus.EDP_AR[0:8] = 9'h0AB;
    applyStimulus(3'd2, 2'd3, 2'd2, 2'b01, 2'b01, 9'h0AA, 1'b0);
    checkOutput("reset_scad", 36'(bus.SCD_SCAD), 36'h155);
    tick();
    tick();
    checkOutput("reset_sc", 36'(bus.SCD_SC), 36'h0);
    checkOutput("reset_fe", 36'(bus.SCD_FE), 36'h0);
    checkOutput("reset_done", 36'(bus.SCD_loopDone), 36'h0);
    eboxReset = 1'b0;

    // Load SC=3 then step through zero
    applyStimulus(3'd0, 2'd3, 2'd0, 2'b01, 2'b00, 9'd3, 1'b0);
    tick();
    checkOutput("load_sc3", 36'(bus.SCD_SC), 36'd3);
    applyStimulus(3'd0, 2'd3, 2'd0, 2'b10, 2'b00, 9'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("step_sc%0d", i), 36'(bus.SCD_SC), 36'(stepExp[i]));
      checkOutput($sformatf("step_done%0d", i), 36'(bus.SCD_loopDone), 36'(doneExp[i]));
    end
    checkOutput("step_scneg", 36'(bus.SCD_SCneg), 36'h1);
    applyStimulus(3'd0, 2'd3, 2'd0, 2'b00, 2'b00, 9'd3, 1'b0);
    tick();
    checkOutput("hold_done", 36'(bus.SCD_loopDone), 36'h0);
    checkOutput("hold_sc", 36'(bus.SCD_SC), 36'h3FF);
    applyStimulus(3'd0, 2'd3, 2'd0, 2'b10, 2'b00, 9'd3, 1'b0);
    tick();
    checkOutput("negstep_sc", 36'(bus.SCD_SC), 36'h3FE);
    checkOutput("negstep_done", 36'(bus.SCD_loopDone), 36'h0);
    checkOutput("armm_lower", 36'(bus.SCD_ARMMlower), 36'h1E);

    // Exponent path from negative AR
    bus.EDP_AR[0:8] = 9'b1_0111_1110;
    applyStimulus(3'd0, 2'd1, 2'd0, 2'b00, 2'b00, 9'd0, 1'b1);
    checkOutput("exp_scad", 36'(bus.SCD_SCAD), 36'h381);
    checkOutput("exp_armm", 36'(bus.SCD_ARMMupper), 36'h181);
    applyStimulus(3'd0, 2'd3, 2'd0, 2'b00, 2'b00, 9'h055, 1'b1);
    checkOutput("armm_insert", 36'(bus.SCD_ARMMupper), 36'h155);
    applyStimulus(3'd0, 2'd3, 2'd0, 2'b00, 2'b00, 9'h055, 1'b0);
    checkOutput("armm_plain", 36'(bus.SCD_ARMMupper), 36'h055);

    // AR field muxes with the logic and increment functions: A=0x2C, B=0x35
    bus.EDP_AR[0:11] = 12'b101100_110101;
    applyStimulus(3'd6, 2'd2, 2'd1, 2'b00, 2'b00, 9'd0, 1'b0);
    checkOutput("fn_or", 36'(bus.SCD_SCAD), 36'h03D);
    applyStimulus(3'd7, 2'd2, 2'd1, 2'b00, 2'b00, 9'd0, 1'b0);
    checkOutput("fn_and", 36'(bus.SCD_SCAD), 36'h024);
    applyStimulus(3'd3, 2'd2, 2'd1, 2'b00, 2'b00, 9'd0, 1'b0);
    checkOutput("fn_dec", 36'(bus.SCD_SCAD), 36'h02B);
    applyStimulus(3'd4, 2'd2, 2'd1, 2'b00, 2'b00, 9'd0, 1'b0);
    checkOutput("fn_inc", 36'(bus.SCD_SCAD), 36'h02D);

    // Subtract and zero detect with FE=SC=40
    applyStimulus(3'd0, 2'd3, 2'd0, 2'b01, 2'b01, 9'd40, 1'b0);
    tick();
    applyStimulus(3'd5, 2'd0, 2'd0, 2'b00, 2'b00, 9'd0, 1'b0);
    checkOutput("sub_scad", 36'(bus.SCD_SCAD), 36'h0);
    checkOutput("sub_eq0", 36'(bus.SCD_SCADeq0), 36'h1);
    applyStimulus(3'd1, 2'd0, 2'd0, 2'b00, 2'b00, 9'd0, 1'b0);
    checkOutput("subm1_scad", 36'(bus.SCD_SCAD), 36'h3FF);
    checkOutput("subm1_eq0", 36'(bus.SCD_SCADeq0), 36'h0);
    applyStimulus(3'd2, 2'd0, 2'd0, 2'b00, 2'b00, 9'd0, 1'b0);
    checkOutput("add_scad", 36'(bus.SCD_SCAD), 36'd80);

    // Swap SC=5, FE=9
    applyStimulus(3'd0, 2'd3, 2'd0, 2'b01, 2'b00, 9'd5, 1'b0);
    tick();
    applyStimulus(3'd0, 2'd3, 2'd0, 2'b00, 2'b01, 9'd9, 1'b0);
    tick();
    applyStimulus(3'd0, 2'd0, 2'd0, 2'b01, 2'b10, 9'd0, 1'b0);
    tick();
    checkOutput("swap_sc", 36'(bus.SCD_SC), 36'd9);
    checkOutput("swap_fe", 36'(bus.SCD_FE), 36'd5);
    applyStimulus(3'd0, 2'd0, 2'd0, 2'b00, 2'b11, 9'd0, 1'b0);
    tick();
    checkOutput("fe_clear", 36'(bus.SCD_FE), 36'd0);
    checkOutput("fe_clear_sc", 36'(bus.SCD_SC), 36'd9);

    // Wrap from 0x200: 0x300 + 0x300 = 0x200
    bus.EDP_AR[0:8] = 9'h100;
    applyStimulus(3'd2, 2'd3, 2'd2, 2'b01, 2'b00, 9'h100, 1'b0);
    tick();
    checkOutput("wrap_load", 36'(bus.SCD_SC), 36'h200);
    checkOutput("wrap_neg", 36'(bus.SCD_SCneg), 36'h1);
    applyStimulus(3'd0, 2'd0, 2'd0, 2'b10, 2'b00, 9'd0, 1'b0);
    tick();
    checkOutput("wrap_sc", 36'(bus.SCD_SC), 36'h1FF);
    checkOutput("wrap_scneg", 36'(bus.SCD_SCneg), 36'h0);
    checkOutput("wrap_done", 36'(bus.SCD_loopDone), 36'h0);

    // Reset during a step sequence aborts without a pulse
    applyStimulus(3'd0, 2'd3, 2'd0, 2'b01, 2'b00, 9'd1, 1'b0);
    tick();
    applyStimulus(3'd0, 2'd3, 2'd0, 2'b10, 2'b00, 9'd1, 1'b0);
    tick();
    checkOutput("abort_pre", 36'(bus.SCD_SC), 36'd0);
    eboxReset = 1'b1;
    tick();
    checkOutput("abort_sc", 36'(bus.SCD_SC), 36'd0);
    checkOutput("abort_done", 36'(bus.SCD_loopDone), 36'h0);
    eboxReset = 1'b0;
    applyStimulus(3'd0, 2'd3, 2'd0, 2'b00, 2'b00, 9'd1, 1'b0);
    tick();
    checkOutput("abort_after", 36'(bus.SCD_loopDone), 36'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
